// File: rtl/mvau_pkg.sv
// Shared types and constants for the MVAU weight and activation stream paths.
package mvau_pkg;

    // Default lane geometry of a weight word
    localparam int unsigned Simd  = 2;
    localparam int unsigned Tw    = 1;
    localparam int unsigned WordW = Simd * Tw;

    typedef logic [WordW-1:0] wgt_word_t;

    // Output buffer depth: one slot for the word in flight plus one for backpressure
    localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/mvau_skid_fifo.sv
// Two-entry register FIFO with push/pop and occupancy output.
// The caller guarantees no push when full and no pop when empty.
module mvau_skid_fifo
    import mvau_pkg::*;
#(
    parameter int unsigned Width = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  logic [Width-1:0]                   data_i,
    input  logic                               pop_i,
    output logic [Width-1:0]                   data_o,
    output logic [$clog2(FifoDepth+1)-1:0]     cnt_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    logic [Width-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_d;

    // Occupancy next state; simultaneous push and pop leaves it unchanged
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy; depth 2 lets the pointers wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign data_o = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/mvau_weight_streamer.sv
// Weight memory read controller: circular address generation, one-cycle read
// latency absorption, and a bubble-free valid/ready weight stream.
module mvau_weight_streamer
    import mvau_pkg::*;
#(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    output logic                    wgt_valid,
    input  logic                    wgt_ready,
    output logic [SIMD*TW-1:0]      wgt_data,
    output logic                    wgt_last
);

    localparam int unsigned WordW = SIMD * TW;
    localparam int unsigned CntW  = $clog2(FifoDepth + 1);
    localparam logic [WMEM_ADDR_BW-1:0] LastAddr = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [WMEM_ADDR_BW-1:0] addr_q;
    logic [WMEM_ADDR_BW-1:0] addr_d;
    logic                    rd_pending_q;
    logic                    last_pend_q;
    logic [CntW-1:0]         fifo_cnt;
    logic                    pop;
    logic                    rd_issue;
    logic [2:0]              occ_after;

    assign pop = wgt_valid & wgt_ready;

    // Issue only if the word would still fit after this cycle's pop and pending push
    always_comb begin
        occ_after = 3'(fifo_cnt) + 3'(rd_pending_q) - 3'(pop);
        rd_issue  = occ_after < 3'(FifoDepth);
    end

    // Circular address advance on each issued read
    always_comb begin
        addr_d = addr_q;
        if (rd_issue) begin
            addr_d = (addr_q == LastAddr) ? '0 : addr_q + WMEM_ADDR_BW'(1);
        end
    end

    // Address counter and in-flight read tracking (data plus its last flag)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q       <= '0;
            rd_pending_q <= 1'b0;
            last_pend_q  <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            rd_pending_q <= rd_issue;
            if (rd_issue) begin
                last_pend_q <= (addr_q == LastAddr);
            end
        end
    end

    mvau_skid_fifo #(
        .Width (WordW + 1)
    ) u_fifo (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .push_i (rd_pending_q),
        .data_i ({last_pend_q, wmem_in}),
        .pop_i  (pop),
        .data_o ({wgt_last, wgt_data}),
        .cnt_o  (fifo_cnt)
    );

    assign wmem_addr = addr_q;
    assign wgt_valid = (fifo_cnt != '0);

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Self-checking bench for mvau_weight_streamer: memory model, scoreboard of
// expected {last,data} words, and directed/random backpressure phases.
module tb_mvau_weight_streamer;

    localparam int unsigned SIMD = 2;
    localparam int unsigned TW   = 1;
    localparam int unsigned D    = 4;
    localparam int unsigned ABW  = 4;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [ABW-1:0] wmem_addr;
    logic [1:0]     wmem_in;
    logic           wgt_valid;
    logic           wgt_ready;
    logic [1:0]     wgt_data;
    logic           wgt_last;

    logic [1:0] rom [D] = '{2'h1, 2'h2, 2'h3, 2'h0};

    int         errors = 0;
    int         checks = 0;
    int         accepts = 0;
    int         ref_idx = 0;
    bit         mon_en = 1'b0;
    bit         held_v = 1'b0;
    logic [2:0] held_w;
    logic [2:0] exp_q [$];

    always #5 aclk = ~aclk;

    mvau_weight_streamer #(
        .SIMD         (SIMD),
        .TW           (TW),
        .WMEM_DEPTH   (D),
        .WMEM_ADDR_BW (ABW)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wmem_addr (wmem_addr),
        .wmem_in   (wmem_in),
        .wgt_valid (wgt_valid),
        .wgt_ready (wgt_ready),
        .wgt_data  (wgt_data),
        .wgt_last  (wgt_last)
    );

    // One-cycle registered read memory
    always @(posedge aclk) wmem_in <= rom[wmem_addr[1:0]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(ref_idx % 4) == 3, rom[ref_idx % 4]});
            ref_idx++;
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        mon_en  = 1'b0;
        aresetn = 1'b0;
        held_v  = 1'b0;
        repeat (2) @(posedge aclk);
    endtask

    task automatic start_stream(input int n, input logic rdy);
        exp_q.delete();
        ref_idx = 0;
        push_expected(n);
        @(negedge aclk);
        wgt_ready = rdy;
        held_v    = 1'b0;
        aresetn   = 1'b1;
        mon_en    = 1'b1;
    endtask

    // Output monitor: hold stability, occupancy bound, scoreboard on every accept
    always @(negedge aclk) begin
        if (mon_en && aresetn) begin
            if (held_v) begin
                check_eq("hold_valid", 32'(wgt_valid), 32'd1);
                check_eq("hold_word", 32'({wgt_last, wgt_data}), 32'(held_w));
            end
            held_v = wgt_valid && !wgt_ready;
            held_w = {wgt_last, wgt_data};
            check_eq("cnt_le2", 32'(dut.fifo_cnt <= 2'd2), 32'd1);
            if (wgt_valid && wgt_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("sb_word", 32'({wgt_last, wgt_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  a0;
        bit  found;
        aresetn   = 1'b0;
        wgt_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_valid", 32'(wgt_valid), 32'd0);
        check_eq("rst_data", 32'(wgt_data), 32'd0);
        check_eq("rst_last", 32'(wgt_last), 32'd0);
        check_eq("rst_addr", 32'(wmem_addr), 32'd0);

        // Startup latency and full-rate streaming
        start_stream(40, 1'b1);
        @(posedge aclk); #1;
        check_eq("valid_c1", 32'(wgt_valid), 32'd0);
        @(posedge aclk); #1;
        check_eq("valid_c2", 32'(wgt_valid), 32'd1);
        check_eq("first_word", 32'(wgt_data), 32'd1);
        a0 = accepts;
        repeat (8) @(posedge aclk);
        check_eq("full_rate", 32'(accepts - a0), 32'd8);

        // Backpressure from the start: two words buffered, address parks at 2
        do_reset();
        start_stream(40, 1'b0);
        repeat (10) @(posedge aclk);
        #1;
        check_eq("bp_valid", 32'(wgt_valid), 32'd1);
        check_eq("bp_data", 32'(wgt_data), 32'd1);
        check_eq("bp_addr", 32'(wmem_addr), 32'd2);
        a0 = accepts;
        wgt_ready = 1'b1;
        repeat (6) @(posedge aclk);
        check_eq("bp_resume", 32'(accepts - a0), 32'd6);

        // Alternating ready across at least three wraps
        do_reset();
        start_stream(60, 1'b1);
        a0 = accepts;
        for (int i = 0; i < 60; i++) begin
            @(posedge aclk); #1;
            wgt_ready = ~wgt_ready;
        end
        check_eq("toggle_cnt", 32'((accepts - a0) >= 12), 32'd1);

        // Random ready
        do_reset();
        start_stream(800, 1'b1);
        a0 = accepts;
        for (int i = 0; i < 1000; i++) begin
            @(posedge aclk); #1;
            wgt_ready = 1'($urandom_range(0, 1));
        end
        check_eq("rand_cnt", 32'((accepts - a0) > 300), 32'd1);

        // Reset right after word 0x2 is accepted
        do_reset();
        start_stream(40, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge aclk);
            if (wgt_valid && wgt_ready && wgt_data == 2'h2) found = 1'b1;
        end
        check_eq("found_w2", 32'(found), 32'd1);
        @(posedge aclk); #1;
        mon_en  = 1'b0;
        aresetn = 1'b0;
        #1;
        check_eq("mid_valid", 32'(wgt_valid), 32'd0);
        check_eq("mid_data", 32'(wgt_data), 32'd0);
        check_eq("mid_last", 32'(wgt_last), 32'd0);
        check_eq("mid_addr", 32'(wmem_addr), 32'd0);
        repeat (2) @(posedge aclk);
        start_stream(40, 1'b1);
        repeat (2) @(posedge aclk);
        #1;
        check_eq("restart_word", 32'(wgt_data), 32'd1);
        repeat (6) @(posedge aclk);

        // Ready released while cnt=1 and a read lands: push and pop together
        do_reset();
        start_stream(40, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        check_eq("pp_pre_cnt", 32'(dut.fifo_cnt), 32'd1);
        check_eq("pp_pre_pend", 32'(dut.rd_pending_q), 32'd1);
        wgt_ready = 1'b1;
        @(posedge aclk); #1;
        check_eq("pp_cnt", 32'(dut.fifo_cnt), 32'd1);
        repeat (10) @(posedge aclk);

        #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvau_weight_streamer.md
# mvau_weight_streamer

Read controller and output buffer between one weight memory bank and the MVAU compute datapath. It generates the weight-memory read address, absorbs the memory's one-cycle registered read latency, and presents weight words as a valid/ready stream. Addresses wrap circularly so the full weight set replays for every input vector. Throughput is one word per cycle with no bubbles under arbitrary consumer backpressure.

## Interface
- SIMD, 2, input lanes per weight word
- TW, 1, weight bit width per lane
- WMEM_DEPTH, 4, number of words in the bank (≥2)
- WMEM_ADDR_BW, 4, address width (2^WMEM_ADDR_BW ≥ WMEM_DEPTH)

Ports:
- aclk  in  1  clock; all logic is rising-edge
- aresetn  in  1  asynchronous, active-low reset
- wmem_addr  out  WMEM_ADDR_BW  read address to the weight memory
- wmem_in  in  SIMD*TW  weight memory read data; valid one cycle after the address is sampled
- wgt_valid  out  1  output word valid
- wgt_ready  in  1  consumer accepts the word
- wgt_data  out  SIMD*TW  weight word
- wgt_last  out  1  high with the word read from address WMEM_DEPTH-1

## Operation
- Address counter `addr`, range 0..WMEM_DEPTH-1. `wmem_addr` = `addr`. On `rd_issue`, `addr` increments, and wraps from WMEM_DEPTH-1 to 0.
- `pop` = wgt_valid & wgt_ready.
- `rd_pending` is a 1-bit flag: set on the cycle after `rd_issue`, meaning wmem_in carries the word for the issued address and its last flag.
- Output buffer is a 2-entry FIFO of {data, last}, with occupancy `cnt` in the range 0..2.
  - Write: when `rd_pending`, capture wmem_in and the last flag of the address issued.
  - Read: on `pop`.
- Issue rule: `rd_issue` = (cnt + rd_pending − pop) < 2. This guarantees the FIFO never overflows and sustains one word per cycle.
- wgt_valid = (cnt ≠ 0). wgt_data and wgt_last come from the FIFO head. They are stable while wgt_valid & !wgt_ready.
- Simultaneous write and pop: occupancy is unchanged, and data order is preserved.
- No start/stop input: streaming begins automatically after reset release.

## Timing
- Reset (async assert, sync to aclk on release):
  - addr=0, rd_pending=0, cnt=0
  - wgt_valid=0, wgt_data=0, wgt_last=0
  - wmem_addr=0
- First word:
  - Cycle 0 after release: `rd_issue` on addr 0.
  - Cycle 1: rd_pending.
  - Cycle 2: wgt_valid=1 with word 0.
  - Startup latency is 2 cycles.
- Steady state with wgt_ready=1: one word per cycle, cnt=1, rd_pending=1 every cycle.
- Backpressure:
  - With wgt_ready held low, at most 2 words are buffered.
  - Issuing stops once cnt + rd_pending reaches 2.
  - On wgt_ready rising, words resume with no gap and no loss or duplication.
- Wrap: the word order is …, D-1(last=1), 0, 1, … with no extra cycle at the wrap.
- Reset mid-stream discards buffered and in-flight words. After release, streaming restarts at address 0.

## Structure
- Shared package `mvau_pkg` holds:
  - the weight word typedef, sized SIMD*TW bits
  - a localparam FIFO depth of 2
- Natural sub-module: `mvau_skid_fifo`, a 2-entry register FIFO with push/pop/cnt, parameterised by width. It is reusable by the activation path. The address counter and issue logic stay in the top module.

## Test plan
All scenarios use SIMD=2, TW=1, WMEM_DEPTH=4, with a memory model holding 0x1, 0x2, 0x3, 0x0 and one-cycle registered read.
- Release reset with wgt_ready=1 -> wgt_valid rises on cycle 2. Data sequence is 1, 2, 3, 0, 1, 2… at one word per cycle, with wgt_last=1 only on 0x0.
- wgt_ready=0 for 10 cycles from the start -> wgt_valid=1 with data 0x1 held stable. wmem_addr stops at 2 (two words buffered). Ready high then yields 1, 2, 3, 0 back-to-back.
- wgt_ready toggling 1,0,1,0… -> the output sequence is still exactly 1, 2, 3, 0 repeating, with no drops or duplicates. The scoreboard checks order across 3 wraps.
- Random wgt_ready (50%) for 1000 cycles -> the accepted sequence matches the modulo-4 reference. cnt never exceeds 2.
- Assert aresetn mid-stream right after word 0x2 is accepted -> all outputs go to 0 immediately. After release, the first word is 0x1 again (address 0).
- wgt_ready held low then released on the same cycle a new read lands (cnt=1, rd_pending=1) -> simultaneous push/pop keeps cnt=1 and preserves order.
